// File: rtl/bram_arb_pkg.sv
// rtl/bram_arb_pkg.sv - shared types and constants for the BRAM port arbiter
// Purpose: word/address typedefs, read-owner enum and read-tag struct used by
//          bram_port_arbiter and bram_rd_tag_pipe.
// Ports:   none (package).
package bram_arb_pkg;

  localparam int BRAM_WORDS      = 512;
  localparam int BRAM_DATA_WIDTH = 64;
  localparam int BRAM_ADDR_WIDTH = $clog2(BRAM_WORDS);

  typedef logic [BRAM_ADDR_WIDTH-1:0] t_bram_addr;
  typedef logic [BRAM_DATA_WIDTH-1:0] t_bram_data;

  typedef enum logic {
    OWN_HOST = 1'b0,
    OWN_CORE = 1'b1
  } t_bram_owner;

  typedef struct packed {
    logic        valid;
    t_bram_owner owner;
  } t_rd_tag;

endpackage

// File: rtl/bram_rd_tag_pipe.sv
// rtl/bram_rd_tag_pipe.sv - RD_LATENCY-deep shift register of read-owner tags
// Purpose: delays the tag of each accepted read so it emerges in the same cycle
//          the BRAM presents the read data. Reset clears every stage, which
//          discards any reads still in flight.
// Ports:   clk, reset_n (async active-low)
//          tag_in  - tag of the read accepted this cycle (valid=0 when none)
//          tag_out - tag aligned with bram_rdata
module bram_rd_tag_pipe
  import bram_arb_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic    clk,
  input  logic    reset_n,
  input  t_rd_tag tag_in,
  output t_rd_tag tag_out
);

  t_rd_tag [RD_LATENCY-1:0] stage_q;
  t_rd_tag [RD_LATENCY-1:0] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[0] = tag_in;
    for (int i = 1; i < RD_LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign tag_out = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// rtl/bram_port_arbiter.sv - round-robin host/core arbiter for a single-port BRAM
// Purpose: grants at most one of the host and core masters per cycle, drives the
//          BRAM directly from the winner, and steers read data back to the port
//          that issued the read.
// Ports:   clk, reset_n (async active-low)
//          h_* - host master: read/write/address/writedata in;
//                waitrequest/readdata/readdatavalid out
//          c_* - core master, same shape as h_*
//          bram_addr/bram_wren/bram_wdata out, bram_rdata in (RD_LATENCY cycles)
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  h_read,
  input  logic                  h_write,
  input  logic [ADDR_WIDTH-1:0] h_address,
  input  logic [DATA_WIDTH-1:0] h_writedata,
  output logic                  h_waitrequest,
  output logic [DATA_WIDTH-1:0] h_readdata,
  output logic                  h_readdatavalid,

  input  logic                  c_read,
  input  logic                  c_write,
  input  logic [ADDR_WIDTH-1:0] c_address,
  input  logic [DATA_WIDTH-1:0] c_writedata,
  output logic                  c_waitrequest,
  output logic [DATA_WIDTH-1:0] c_readdata,
  output logic                  c_readdatavalid,

  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_wren,
  output logic [DATA_WIDTH-1:0] bram_wdata,
  input  logic [DATA_WIDTH-1:0] bram_rdata
);

  t_bram_owner           last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0] addr_hold_q, addr_hold_d;
  logic                  h_req, c_req;
  logic                  grant_h, grant_c;
  t_rd_tag               tag_in, tag_out;

  always_comb begin
    h_req   = h_read | h_write;
    c_req   = c_read | c_write;
    grant_h = 1'b0;
    grant_c = 1'b0;
    // Grants are gated by reset_n so both masters see waitrequest=1 for the
    // whole time reset is held, whatever they are requesting.
    if (reset_n) begin
      if (h_req && (!c_req || last_grant_q == OWN_CORE)) begin
        grant_h = 1'b1;
      end else if (c_req) begin
        grant_c = 1'b1;
      end
    end

    last_grant_d = last_grant_q;
    if (grant_h) last_grant_d = OWN_HOST;
    if (grant_c) last_grant_d = OWN_CORE;

    // Idle cycles keep presenting the previous address to the BRAM.
    bram_addr = addr_hold_q;
    if (grant_h)      bram_addr = h_address;
    else if (grant_c) bram_addr = c_address;
    addr_hold_d = bram_addr;

    bram_wdata = grant_c ? c_writedata : h_writedata;
    bram_wren  = (grant_h & h_write) | (grant_c & c_write);

    // Read+write together is a write; the read half is dropped.
    tag_in.valid = (grant_h & h_read & ~h_write) | (grant_c & c_read & ~c_write);
    tag_in.owner = grant_c ? OWN_CORE : OWN_HOST;

    h_waitrequest   = ~grant_h;
    c_waitrequest   = ~grant_c;
    h_readdatavalid = tag_out.valid & (tag_out.owner == OWN_HOST);
    c_readdatavalid = tag_out.valid & (tag_out.owner == OWN_CORE);
    h_readdata      = bram_rdata;
    c_readdata      = bram_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= OWN_CORE;
      addr_hold_q  <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      addr_hold_q  <= addr_hold_d;
    end
  end

  bram_rd_tag_pipe #(
    .RD_LATENCY(RD_LATENCY)
  ) u_rd_tag_pipe (
    .clk    (clk),
    .reset_n(reset_n),
    .tag_in (tag_in),
    .tag_out(tag_out)
  );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb/tb_bram_port_arbiter.sv - scoreboard bench for bram_port_arbiter (RD_LATENCY 1 and 3)
module tb_bram_port_arbiter;

  localparam int AW = 9;
  localparam int DW = 64;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          h_read = 1'b0, h_write = 1'b0, c_read = 1'b0, c_write = 1'b0;
  logic [AW-1:0] h_address = '0, c_address = '0;
  logic [DW-1:0] h_writedata = '0, c_writedata = '0;

  // Index 0: RD_LATENCY=1 instance, index 1: RD_LATENCY=3 instance.
  logic [1:0]    h_wait, c_wait, h_vld, c_vld, b_wren;
  logic [DW-1:0] h_rdat [2];
  logic [DW-1:0] c_rdat [2];
  logic [DW-1:0] b_wdata [2];
  logic [DW-1:0] b_rdata [2];
  logic [AW-1:0] b_addr [2];

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n),
    .h_read(h_read), .h_write(h_write), .h_address(h_address), .h_writedata(h_writedata),
    .h_waitrequest(h_wait[0]), .h_readdata(h_rdat[0]), .h_readdatavalid(h_vld[0]),
    .c_read(c_read), .c_write(c_write), .c_address(c_address), .c_writedata(c_writedata),
    .c_waitrequest(c_wait[0]), .c_readdata(c_rdat[0]), .c_readdatavalid(c_vld[0]),
    .bram_addr(b_addr[0]), .bram_wren(b_wren[0]), .bram_wdata(b_wdata[0]), .bram_rdata(b_rdata[0])
  );

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .h_read(h_read), .h_write(h_write), .h_address(h_address), .h_writedata(h_writedata),
    .h_waitrequest(h_wait[1]), .h_readdata(h_rdat[1]), .h_readdatavalid(h_vld[1]),
    .c_read(c_read), .c_write(c_write), .c_address(c_address), .c_writedata(c_writedata),
    .c_waitrequest(c_wait[1]), .c_readdata(c_rdat[1]), .c_readdatavalid(c_vld[1]),
    .bram_addr(b_addr[1]), .bram_wren(b_wren[1]), .bram_wdata(b_wdata[1]), .bram_rdata(b_rdata[1])
  );

  // Behavioural BRAMs, one per instance; word i starts out holding value i.
  logic [DW-1:0] mem [2][512];
  logic [DW-1:0] pipe [2][3];
  logic          mem_loaded = 1'b0;
  assign b_rdata[0] = pipe[0][0];
  assign b_rdata[1] = pipe[1][2];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!mem_loaded) begin
        for (int i = 0; i < 512; i++) mem[k][i] <= 64'(i);
      end else if (b_wren[k]) begin
        mem[k][b_addr[k]] <= b_wdata[k];
      end
      pipe[k][2] <= pipe[k][1];
      pipe[k][1] <= pipe[k][0];
      pipe[k][0] <= mem[k][b_addr[k]];
    end
    mem_loaded <= 1'b1;
  end

  // Reference model state
  logic [DW-1:0] mdl_mem [512];
  bit            mdl_last_core;
  exp_t          expq [4][$];   // inst*2 + port (0 host, 1 core)
  int            cyc = 0;
  int            vectors = 0;
  int            miscompares = 0;
  bit            acc_h, acc_c;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Round-robin and data rules applied to the current request inputs.
  task automatic model_cycle();
    bit            hq, cq, gh, gc, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    hq = h_read | h_write;
    cq = c_read | c_write;
    gh = hq && (!cq || mdl_last_core);
    gc = cq && !gh;
    wr = gh ? h_write : c_write;
    a  = gh ? h_address : c_address;
    d  = gh ? h_writedata : c_writedata;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("h_waitrequest[%0d]", k), 64'(h_wait[k]), 64'(!gh));
      chk($sformatf("c_waitrequest[%0d]", k), 64'(c_wait[k]), 64'(!gc));
      chk($sformatf("bram_wren[%0d]", k), 64'(b_wren[k]), 64'((gh || gc) && wr));
      if (gh || gc) chk($sformatf("bram_addr[%0d]", k), 64'(b_addr[k]), 64'(a));
      if ((gh || gc) && wr) chk($sformatf("bram_wdata[%0d]", k), b_wdata[k], d);
    end
    if (gh || gc) begin
      mdl_last_core = gc;
      if (wr) begin
        mdl_mem[a] = d;
      end else begin
        expq[gc ? 1 : 0].push_back('{data: mdl_mem[a], due: cyc + 1});
        expq[gc ? 3 : 2].push_back('{data: mdl_mem[a], due: cyc + 3});
      end
    end
    acc_h = gh;
    acc_c = gc;
  endtask

  task automatic apply(input bit hr, input bit hw, input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                       input bit cr, input bit cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd);
    h_read = hr; h_write = hw; h_address = ha; h_writedata = hd;
    c_read = cr; c_write = cw; c_address = ca; c_writedata = cd;
    @(negedge clk);
    model_cycle();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) apply(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    for (int k = 0; k < 4; k++) expq[k].delete();
    mdl_last_core = 1'b1;
    h_read = 1'b1; h_write = 1'b0; c_read = 1'b1; c_write = 1'b0;
    repeat (n) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rst_h_waitrequest[%0d]", k), 64'(h_wait[k]), 64'd1);
        chk($sformatf("rst_c_waitrequest[%0d]", k), 64'(c_wait[k]), 64'd1);
        chk($sformatf("rst_bram_wren[%0d]", k), 64'(b_wren[k]), 64'd0);
        chk($sformatf("rst_bram_addr[%0d]", k), 64'(b_addr[k]), 64'd0);
      end
      @(posedge clk);
      cyc++;
      #1;
    end
    reset_n = 1'b1;
  endtask

  // Monitor: pops expected read returns whenever a readdatavalid is seen.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      logic          v;
      logic [DW-1:0] d;
      exp_t          e;
      v = (k % 2) ? c_vld[k/2] : h_vld[k/2];
      d = (k % 2) ? c_rdat[k/2] : h_rdat[k/2];
      if (v) begin
        if (expq[k].size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL readdatavalid_unexpected[%0d]: got 1, expected 0 (cycle %0d)", k, cyc);
        end else begin
          e = expq[k].pop_front();
          chk($sformatf("read_latency[%0d]", k), 64'(cyc), 64'(e.due));
          chk($sformatf("readdata[%0d]", k), d, e.data);
        end
      end else if (expq[k].size() > 0 && expq[k][0].due <= cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL readdatavalid_missing[%0d]: got 0, expected 1 (due cycle %0d, cycle %0d)",
                 k, expq[k][0].due, cyc);
        void'(expq[k].pop_front());
      end
    end
  end

  initial begin
    bit            h_pend, c_pend;
    int            op;
    for (int i = 0; i < 512; i++) mdl_mem[i] = 64'(i);
    @(posedge clk);
    #1;
    do_reset(2);

    // Host write then read of 0x20
    apply(0, 1, 9'h20, 64'hDEAD_BEEF_0123_4567, 0, 0, '0, '0);
    apply(1, 0, 9'h20, '0, 0, 0, '0, '0);
    idle(4);

    // Contended reads from reset: H,C,H,C
    do_reset(2);
    repeat (4) apply(1, 0, 9'd5, '0, 1, 0, 9'd6, '0);
    idle(4);

    // Core write and host read to the same word in the same cycle
    apply(1, 0, 9'd7, '0, 0, 1, 9'd7, 64'hA5A5);
    apply(0, 0, '0, '0, 0, 1, 9'd7, 64'hA5A5);
    apply(1, 0, 9'd7, '0, 0, 0, '0, '0);
    idle(4);

    // Back-to-back core reads 0..15
    for (int i = 0; i < 16; i++) apply(0, 0, '0, '0, 1, 0, 9'(i), '0);
    idle(4);

    // Reset with a host read in flight, then normal traffic
    apply(1, 0, 9'h20, '0, 0, 0, '0, '0);
    do_reset(2);
    apply(1, 0, 9'h20, '0, 1, 0, 9'd5, '0);
    apply(0, 0, '0, '0, 1, 0, 9'd5, '0);
    idle(4);

    // Random mixed traffic; masters hold their request until accepted
    h_pend = 0;
    c_pend = 0;
    for (int n = 0; n < 10000; n++) begin
      if (!h_pend) begin
        op = $urandom_range(0, 7);
        h_read      = (op >= 2 && op <= 4) || op == 7;
        h_write     = (op >= 5);
        h_address   = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
        h_writedata = {$urandom, $urandom};
        h_pend      = h_read | h_write;
      end
      if (!c_pend) begin
        op = $urandom_range(0, 7);
        c_read      = (op >= 2 && op <= 4) || op == 7;
        c_write     = (op >= 5);
        c_address   = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 15)) : 9'($urandom_range(0, 511));
        c_writedata = {$urandom, $urandom};
        c_pend      = c_read | c_write;
      end
      apply(h_read, h_write, h_address, h_writedata, c_read, c_write, c_address, c_writedata);
      if (acc_h) h_pend = 0;
      if (acc_c) c_pend = 0;
    end
    idle(6);

    for (int k = 0; k < 4; k++) chk($sformatf("drain_empty[%0d]", k), 64'(expq[k].size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
